mem_access_stage: RTL and testbench

Memory stage of the pipelined RV32I core, between the Execute/Memory pipeline register and the Writeback stage. It takes a load or store from the M stage and drives a word-addressed data-memory port with a req/ready handshake. It builds byte enables and replicated store data, and sign/zero-extends load data. It also contains the Memory/Writeback pipeline register. It raises StallM to freeze the upstream stages while memory is not ready, and aborts a hung access after a bounded wait.

---
 rtl/mem_access_stage.sv | 138 +++++++++++++
 tb/tb_mem_access_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory stage: aligned load/store over a req/ready data port with a
// bounded wait, byte-lane steering, load extension and the M/W pipeline register.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  RegWriteM,
  input  logic                  ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [4:0]            RdW,
  output logic                  MisalignW,
  output logic                  BusErrW
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic             access, aligned, misalign, last_wait, abort;
  logic [1:0]       lane;
  logic [31:0]      shifted, load_data;

  always_comb begin
    access = MemWriteM | ResultSrcM;
    lane   = ALUResultM[1:0];
    case (Funct3M[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    misalign = access & ~aligned;
    // WAIT keeps requesting on its own; M inputs are held stable by StallM anyway
    mem_req   = ~rst & ((state == S_WAIT) | (access & aligned));
    last_wait = (state == S_WAIT) & (wait_cnt == WCW'(TIMEOUT - 1));
    abort     = mem_req & ~mem_ready & last_wait;
    StallM    = mem_req & ~mem_ready & ~last_wait;
    mem_we    = mem_req & MemWriteM;
    mem_addr  = {ALUResultM[31:2], 2'b00};

    mem_be = '0;
    if (mem_req) begin
      if (MemWriteM) begin
        case (Funct3M[1:0])
          2'b00:   mem_be = 4'b0001 << lane;
          2'b01:   mem_be = 4'b0011 << lane;
          default: mem_be = 4'b1111;
        endcase
      end else begin
        mem_be = 4'b1111;
      end
    end

    case (Funct3M[1:0])
      2'b00:   mem_wdata = {4{WriteDataM[7:0]}};
      2'b01:   mem_wdata = {2{WriteDataM[15:0]}};
      default: mem_wdata = WriteDataM;
    endcase

    shifted = mem_rdata >> {lane, 3'b000};
    case (Funct3M)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req & ~mem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ready | last_wait) state <= S_IDLE;
          else                       wait_cnt <= wait_cnt + WCW'(1);
        end
        default: state <= S_IDLE;
      endcase

      // Bubble clears only control bits; data fields keep their last values
      if (StallM) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 1'b0;
        MisalignW  <= 1'b0;
        BusErrW    <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM & ~misalign & ~abort;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        MisalignW  <= misalign;
        BusErrW    <= abort;
        if (mem_req & mem_ready & ~MemWriteM) ReadDataW <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised and directed bench for mem_access_stage against a transaction-level
// model of the alignment, lane, wait/timeout and writeback rules.
module tb_mem_access_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, mem_rdata;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, MemWriteM, mem_ready;
  logic [2:0]  Funct3M;
  logic        mem_req, mem_we, StallM;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        RegWriteW, ResultSrcW, MisalignW, BusErrW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  int unsigned vectors = 0, miscompares = 0;
  int unsigned waited = 0;
  logic        model_stall = 1'b0;
  logic        e_rw = 0, e_rs = 0, e_mis = 0, e_berr = 0;
  logic [31:0] e_alu = 0, e_rd = 0, e_pc = 0;
  logic [4:0]  e_rdn = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned a,
                                             input logic [31:0] w);
    int unsigned sh, b, h;
    sh = w >> (8 * a);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One clock: check combinational outputs mid-cycle, then W outputs after the edge
  task automatic cycle(output int unsigned req_seen, output int unsigned stall_seen);
    logic        acc, aln, mis, req, stall, abort, done;
    int unsigned a, n;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    a   = int'(ALUResultM[1:0]);
    n   = 32'd1 << Funct3M[1:0];
    acc = MemWriteM || ResultSrcM;
    aln = (Funct3M[1:0] != 2'd3) && (ALUResultM % n == 0);
    mis = acc && !aln;
    req = !rst && acc && aln;
    stall = req && !mem_ready && (waited < TMO);
    abort = req && !mem_ready && (waited >= TMO);
    done  = req && mem_ready;
    be = '0;
    wd = '0;
    if (req) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (MemWriteM) begin
          be[i] = (i >= a) && (i < a + n);
          wd[8*i +: 8] = WriteDataM[8*(i % n) +: 8];
        end else begin
          be[i] = 1'b1;
        end
      end
    end
    chk("mem_req", 32'(mem_req), 32'(req));
    chk("mem_we", 32'(mem_we), 32'(req && MemWriteM));
    chk("mem_be", 32'(mem_be), 32'(be));
    chk("StallM", 32'(StallM), 32'(stall));
    if (!rst) chk("mem_addr", mem_addr, ALUResultM - a);
    if (req && MemWriteM) chk("mem_wdata", mem_wdata, wd);
    req_seen   = int'(mem_req);
    stall_seen = int'(StallM);
    last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;

    if (rst) begin
      e_rw = 0; e_rs = 0; e_mis = 0; e_berr = 0;
      e_alu = 0; e_rd = 0; e_pc = 0; e_rdn = 0;
    end else if (stall) begin
      e_rw = 0; e_rs = 0; e_mis = 0; e_berr = 0;
    end else begin
      e_rw = RegWriteM && !mis && !abort;
      e_rs = ResultSrcM;
      e_alu = ALUResultM; e_pc = PCPlus4M; e_rdn = RdM;
      e_mis = mis; e_berr = abort;
      if (done && !MemWriteM) e_rd = model_load(Funct3M, a, mem_rdata);
    end
    waited = (!rst && stall) ? waited + 1 : 0;
    model_stall = stall;

    @(posedge clk);
    #1;
    chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
    chk("MisalignW", 32'(MisalignW), 32'(e_mis));
    chk("BusErrW", 32'(BusErrW), 32'(e_berr));
    chk("ALUResultW", ALUResultW, e_alu);
    chk("PCPlus4W", PCPlus4W, e_pc);
    chk("RdW", 32'(RdW), 32'(e_rdn));
    chk("ReadDataW", ReadDataW, e_rd);
  endtask

  // Present one instruction, hold it while the model says stalled; ready after nw
  // cycles, reset asserted on cycle rst_at (999 = never)
  task automatic issue(input logic we, input logic ld, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                       input int unsigned nw, input int unsigned rst_at,
                       output int unsigned nreq, output int unsigned nstall);
    int unsigned k, r, s;
    k = 0; nreq = 0; nstall = 0;
    MemWriteM = we; ResultSrcM = ld; RegWriteM = rw; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wdat;
    RdM = 5'($urandom); PCPlus4M = $urandom;
    do begin
      mem_ready = (k >= nw);
      mem_rdata = mem_ready ? rdat : $urandom;
      rst = (k == rst_at);
      cycle(r, s);
      nreq += r; nstall += s; k++;
    end while (model_stall && k < 40);
    rst = 1'b0;
    if (model_stall) begin
      vectors++; miscompares++;
      $display("FAIL access_bound: stall persisted %0d cycles, limit 40", k);
    end
  endtask

  int unsigned nr, ns;

  initial begin
    rst = 1'b1; mem_ready = 0; mem_rdata = 0;
    MemWriteM = 0; ResultSrcM = 0; RegWriteM = 0; Funct3M = 0;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
    issue(0, 0, 1, 3'd0, 32'h0, 0, 0, 0, 0, nr, ns);
    chk("rst_RegWriteW", 32'(RegWriteW), 0);
    chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_RdW", 32'(RdW), 0);

    issue(0, 1, 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 999, nr, ns);
    chk("lw_nostall", ns, 0);
    chk("lw_data", ReadDataW, 32'hDEADBEEF);
    chk("lw_rw", 32'(RegWriteW), 1);
    chk("lw_rs", 32'(ResultSrcW), 1);

    issue(0, 1, 1, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 999, nr, ns);
    chk("lb_data", ReadDataW, 32'hFFFFFF80);
    issue(0, 1, 1, 3'b100, 32'h103, 0, 32'h80FF1234, 0, 999, nr, ns);
    chk("lbu_data", ReadDataW, 32'h00000080);

    issue(1, 0, 0, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 999, nr, ns);
    chk("sh_be", 32'(last_be), 32'h0000000C);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(last_we), 1);
    issue(1, 0, 0, 3'b000, 32'h201, 32'h000000A5, 0, 0, 999, nr, ns);
    chk("sb_be", 32'(last_be), 32'h00000002);

    issue(0, 1, 1, 3'b010, 32'h300, 0, 32'h12345678, 3, 999, nr, ns);
    chk("wait3_stall", ns, 3);
    chk("wait3_data", ReadDataW, 32'h12345678);
    issue(0, 0, 1, 3'b000, 32'h44, 0, 0, 0, 999, nr, ns);
    chk("wait3_idle_after", ns, 0);

    issue(0, 1, 1, 3'b010, 32'h400, 0, 0, 99, 999, nr, ns);
    chk("tmo_req", nr, TMO + 1);
    chk("tmo_stall", ns, TMO);
    chk("tmo_buserr", 32'(BusErrW), 1);
    chk("tmo_rw", 32'(RegWriteW), 0);
    issue(0, 0, 1, 3'b000, 32'h55, 0, 0, 0, 999, nr, ns);
    chk("tmo_next_buserr", 32'(BusErrW), 0);
    chk("tmo_next_rw", 32'(RegWriteW), 1);

    issue(0, 1, 1, 3'b010, 32'h404, 0, 32'hCAFEF00D, TMO, 999, nr, ns);
    chk("late_req", nr, TMO + 1);
    chk("late_stall", ns, TMO);
    chk("late_buserr", 32'(BusErrW), 0);
    chk("late_data", ReadDataW, 32'hCAFEF00D);
    chk("late_rw", 32'(RegWriteW), 1);

    issue(0, 1, 1, 3'b010, 32'h102, 0, 0, 0, 999, nr, ns);
    chk("mis_req", nr, 0);
    chk("mis_stall", ns, 0);
    chk("mis_pulse", 32'(MisalignW), 1);
    chk("mis_rw", 32'(RegWriteW), 0);

    issue(0, 1, 1, 3'b010, 32'h500, 0, 0, 99, 2, nr, ns);
    chk("rstwait_rw", 32'(RegWriteW), 0);
    chk("rstwait_buserr", 32'(BusErrW), 0);
    issue(0, 1, 1, 3'b010, 32'h504, 0, 32'h0BADF00D, 0, 999, nr, ns);
    chk("rstwait_idle_req", nr, 1);
    chk("rstwait_idle_stall", ns, 0);
    chk("rstwait_buserr2", 32'(BusErrW), 0);

    for (int t = 0; t < 300; t++) begin
      int unsigned kind, sel, nw, ra;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: nw = 0;
        4:          nw = 1;
        5:          nw = $urandom_range(2, 3);
        6:          nw = TMO;
        default:    nw = TMO + $urandom_range(1, 3);
      endcase
      ra = ($urandom_range(0, 30) == 0) ? $urandom_range(0, 3) : 999;
      if (kind == 1) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b011;
        endcase
        issue(0, 1, 1'($urandom), f3, $urandom, $urandom, $urandom, nw, ra, nr, ns);
      end else if (kind == 2) begin
        f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
        issue(1, 0, 1'($urandom), f3, $urandom, $urandom, $urandom, nw, ra, nr, ns);
      end else begin
        issue(0, 0, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 0, ra, nr, ns);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
